// File: rtl/dmem_pkg.sv
// Shared definitions for the load/store data memory: funct3 codes, FSM states
// and the byte-lane / extension helpers used by the controller.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        if (we)
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the store data lets the lane mask alone pick the destination.
    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
        case (funct3[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] funct3,
                                                input logic [1:0] off);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (funct3)
            F3_B:    return {{24{s[7]}}, s[7:0]};
            F3_H:    return {{16{s[15]}}, s[15:0]};
            F3_W:    return s;
            F3_BU:   return {24'h0, s[7:0]};
            F3_HU:   return {16'h0, s[15:0]};
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide RAM with per-byte write enables and a registered read port.
module dmem_ram #(
    parameter int DEPTH_WORDS = 512
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [3:0]                     we,
    input  logic [31:0]                    wdata,
    input  logic                           re,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of the data RAM: single outstanding request, access
// checks, byte-lane stores and a READ_LAT-cycle load response pipeline.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int ADDR_W      = 32,
    parameter int READ_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state, state_n;
    logic [1:0]  cnt, cnt_n;
    logic        accept, misalign, out_of_range, req_err;
    logic        err_q, load_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [3:0]  ram_we;
    logic        ram_re;
    logic [31:0] ram_q, ext_now, load_data;

    assign accept       = req_valid && req_ready;
    assign misalign     = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                          (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign out_of_range = req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS);
    assign req_err      = !f3_legal(req_we, req_funct3) || misalign || out_of_range;

    assign ram_we = (accept && req_we && !req_err) ? lane_mask(req_funct3, req_addr[1:0]) : 4'b0000;
    assign ram_re = accept && !req_we && !req_err;

    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .addr  (req_addr[AW+1:2]),
        .we    (ram_we),
        .wdata (store_data(req_funct3, req_wdata)),
        .re    (ram_re),
        .rdata (ram_q)
    );

    // The response cycle doubles as an accept cycle, so ready is up there too.
    assign req_ready  = (state == IDLE) || (cnt == 2'd0);
    assign resp_valid = (state == BUSY) && (cnt == 2'd0);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && load_q && !err_q) ? load_data : 32'h0;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == BUSY) begin
            if (cnt == 2'd0) state_n = IDLE;
            else             cnt_n   = cnt - 2'd1;
        end
        if (accept) begin
            state_n = BUSY;
            cnt_n   = (req_we || req_err) ? 2'd0 : 2'(READ_LAT - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            err_q  <= 1'b0;
            load_q <= 1'b0;
            f3_q   <= 3'b000;
            off_q  <= 2'b00;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                err_q  <= req_err;
                load_q <= !req_we;
                f3_q   <= req_funct3;
                off_q  <= req_addr[1:0];
            end
        end
    end

    // ram_q holds until the next load accept, so the extended word can be
    // sampled freely every cycle on its way to the response.
    assign ext_now = load_extend(ram_q, f3_q, off_q);

    if (READ_LAT == 1) begin : g_lat1
        assign load_data = ext_now;
    end else begin : g_latn
        logic [31:0] stage [READ_LAT-1];
        always_ff @(posedge clk) begin
            stage[0] <= ext_now;
            for (int k = 1; k < READ_LAT - 1; k++) stage[k] <= stage[k-1];
        end
        assign load_data = stage[READ_LAT-2];
    end

endmodule
